// File: rtl/float_fifo.sv
// float_fifo: DEPTH-entry first-word-fall-through FIFO of float_pkg::float_t
// with valid/ready on both sides, optional subnormal flush on write and a
// saturating count of accepted NaN words.

package float_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;
endpackage

module float_fifo
    import float_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter bit FLUSH_SUBNORMAL = 1'b0,
    parameter int NAN_CNT_W       = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    input  float_t                       wdata_i,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output float_t                       rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [NAN_CNT_W-1:0]         nan_count_o,
    input  logic                         clr_stats_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
    localparam logic [NAN_CNT_W-1:0] NAN_MAX  = {NAN_CNT_W{1'b1}};

    // NaN: all-ones exponent with a non-zero mantissa (infinity excluded).
    function automatic logic is_nan(input float_t f);
        return (f.exponent == 8'hFF) && (f.mantissa != 23'h000000);
    endfunction

    // Subnormal: zero exponent with a non-zero mantissa.
    function automatic logic is_subnormal(input float_t f);
        return (f.exponent == 8'h00) && (f.mantissa != 23'h000000);
    endfunction

    // Value actually stored for an accepted word.
    function automatic float_t write_xform(input float_t f);
        float_t r;
        if (FLUSH_SUBNORMAL && is_subnormal(f)) begin
            r = '{sign: f.sign, exponent: 8'h00, mantissa: 23'h000000};
        end else begin
            r = f;
        end
        return r;
    endfunction

    // Modulo-DEPTH increment with an explicit wrap, safe for any DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    float_t                 mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [NAN_CNT_W-1:0]   nan_cnt_r;
    float_t                 head_r;
    logic                   rvalid_r;
    logic                   wready_r;

    logic                   push_s;
    logic                   pop_s;
    logic [PTR_W-1:0]       wr_ptr_nxt_s;
    logic [PTR_W-1:0]       rd_ptr_nxt_s;
    logic [CNT_W-1:0]       count_nxt_s;
    float_t                 store_s;

    // Handshake decode and next-state computation from registered flags only.
    always_comb begin
        push_s       = wvalid_i & wready_r;
        pop_s        = rvalid_r & rready_i;
        store_s      = write_xform(wdata_i);
        wr_ptr_nxt_s = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents are only ever seen through the head register.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= store_s;
        end
    end

    // Pointers, occupancy and the registered ready/valid flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            rvalid_r <= 1'b0;
            wready_r <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            rvalid_r <= (count_nxt_s != {CNT_W{1'b0}});
            wready_r <= (count_nxt_s != CNT_FULL);
        end
    end

    // Registered head: the word at the next read pointer, taken straight from
    // the write path when that slot is being written this same cycle. Holds
    // its last value when the FIFO goes empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_r <= '{sign: 1'b0, exponent: 8'h00, mantissa: 23'h000000};
        end else if (count_nxt_s != {CNT_W{1'b0}}) begin
            if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
                head_r <= store_s;
            end else begin
                head_r <= mem_r[rd_ptr_nxt_s];
            end
        end else begin
            head_r <= head_r;
        end
    end

    // Saturating NaN counter; clear has priority over a same-cycle NaN push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nan_cnt_r <= {NAN_CNT_W{1'b0}};
        end else if (clr_stats_i) begin
            nan_cnt_r <= {NAN_CNT_W{1'b0}};
        end else if (push_s && is_nan(wdata_i) && (nan_cnt_r != NAN_MAX)) begin
            nan_cnt_r <= nan_cnt_r + NAN_CNT_W'(1);
        end else begin
            nan_cnt_r <= nan_cnt_r;
        end
    end

    assign wready_o    = wready_r;
    assign rvalid_o    = rvalid_r;
    assign rdata_o     = head_r;
    assign count_o     = count_r;
    assign nan_count_o = nan_cnt_r;

endmodule

// File: tb/tb_float_fifo.sv
// Directed bench for float_fifo: instance a is DEPTH=4 with subnormal flush
// and a 2-bit NaN counter, instance b is DEPTH=3 storing values unchanged.
module tb_float_fifo;
    import float_pkg::*;

    logic        clk;
    logic        rst_a, rst_b;
    logic        wvalid_a, rready_a, clr_a, wready_a, rvalid_a;
    logic        wvalid_b, rready_b, clr_b, wready_b, rvalid_b;
    float_t      wdata_a, rdata_a, wdata_b, rdata_b;
    logic [2:0]  count_a;
    logic [1:0]  nan_a;
    logic [1:0]  count_b;
    logic [7:0]  nan_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    float_fifo #(.DEPTH(4), .FLUSH_SUBNORMAL(1'b1), .NAN_CNT_W(2)) u_a (
        .clk_i(clk), .rst_i(rst_a), .wvalid_i(wvalid_a), .wready_o(wready_a),
        .wdata_i(wdata_a), .rvalid_o(rvalid_a), .rready_i(rready_a),
        .rdata_o(rdata_a), .count_o(count_a), .nan_count_o(nan_a),
        .clr_stats_i(clr_a));

    float_fifo #(.DEPTH(3), .FLUSH_SUBNORMAL(1'b0), .NAN_CNT_W(8)) u_b (
        .clk_i(clk), .rst_i(rst_b), .wvalid_i(wvalid_b), .wready_o(wready_b),
        .wdata_i(wdata_b), .rvalid_o(rvalid_b), .rready_i(rready_b),
        .rdata_o(rdata_b), .count_o(count_b), .nan_count_o(nan_b),
        .clr_stats_i(clr_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill_v [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] nan_in [5] = '{32'h7FC00000, 32'hFF800001, 32'h7F800000, 32'h7FC00000, 32'h7FC00001};
    logic [31:0] nan_exp [5] = '{32'd1, 32'd2, 32'd2, 32'd3, 32'd3};
    logic [31:0] fl_in [3]  = '{32'h00000001, 32'h80000001, 32'h00800000};
    logic [31:0] fl_exp [3] = '{32'h00000000, 32'h80000000, 32'h00800000};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        wvalid_a = 1'b0; rready_a = 1'b0; clr_a = 1'b0; wdata_a = float_t'(32'h0);
        wvalid_b = 1'b0; rready_b = 1'b0; clr_b = 1'b0; wdata_b = float_t'(32'h0);
        #12;
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Reset state
        check_vec("rst_count", 32'(count_a), 32'd0);
        check_vec("rst_rvalid", 32'(rvalid_a), 32'd0);
        check_vec("rst_wready", 32'(wready_a), 32'd1);
        check_vec("rst_rdata", rdata_a, 32'h0);
        check_vec("rst_nan", 32'(nan_a), 32'd0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            wvalid_a = 1'b1; wdata_a = float_t'(fill_v[i]);
            tick();
            if (i == 0) begin
                check_vec("first_rvalid", 32'(rvalid_a), 32'd1);
                check_vec("first_rdata", rdata_a, fill_v[0]);
            end
        end
        wvalid_a = 1'b0;
        check_vec("full_count", 32'(count_a), 32'd4);
        check_vec("full_wready", 32'(wready_a), 32'd0);

        // Drain in order
        rready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_vec("drain_data", rdata_a, fill_v[i]);
            tick();
        end
        rready_a = 1'b0;
        check_vec("empty_rvalid", 32'(rvalid_a), 32'd0);
        check_vec("empty_count", 32'(count_a), 32'd0);

        // Full plus simultaneous pop: write refused, accepted next cycle
        for (int i = 0; i < 4; i++) begin
            wvalid_a = 1'b1; wdata_a = float_t'(fill_v[i]);
            tick();
        end
        wdata_a = float_t'(32'hC0000000); rready_a = 1'b1;
        tick();
        check_vec("fullpop_count", 32'(count_a), 32'd3);
        rready_a = 1'b0;
        tick();
        check_vec("fullpop_accept", 32'(count_a), 32'd4);
        wvalid_a = 1'b0; rready_a = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check_vec("fullpop_data", rdata_a, fill_v[i]);
            tick();
        end
        check_vec("fullpop_last", rdata_a, 32'hC0000000);
        tick();
        rready_a = 1'b0;
        check_vec("fullpop_empty", 32'(count_a), 32'd0);

        // Subnormal flush on instance a, bit-exact on instance b
        for (int i = 0; i < 3; i++) begin
            wvalid_a = 1'b1; wdata_a = float_t'(fl_in[i]);
            wvalid_b = 1'b1; wdata_b = float_t'(fl_in[i]);
            tick();
        end
        wvalid_a = 1'b0; wvalid_b = 1'b0; rready_a = 1'b1; rready_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_vec("flush_on", rdata_a, fl_exp[i]);
            check_vec("flush_off", rdata_b, fl_in[i]);
            tick();
        end
        rready_a = 1'b0; rready_b = 1'b0;

        // NaN statistics with saturation; consumer keeps popping
        rready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wvalid_a = 1'b1; wdata_a = float_t'(nan_in[i]);
            tick();
            check_vec("nan_count", 32'(nan_a), nan_exp[i]);
        end
        clr_a = 1'b1; wdata_a = float_t'(32'h7FC00000);
        tick();
        clr_a = 1'b0; wvalid_a = 1'b0;
        check_vec("nan_clr", 32'(nan_a), 32'd0);
        check_vec("nan_clr_cnt", 32'(count_a), 32'd1);
        tick();
        rready_a = 1'b0;
        check_vec("nan_drained", 32'(count_a), 32'd0);

        // NaN offered while full is not counted
        for (int i = 0; i < 4; i++) begin
            wvalid_a = 1'b1; wdata_a = float_t'(fill_v[i]);
            tick();
        end
        wdata_a = float_t'(32'h7FC00000);
        tick();
        wvalid_a = 1'b0;
        check_vec("nan_full", 32'(nan_a), 32'd0);
        rready_a = 1'b1;
        repeat (4) tick();
        rready_a = 1'b0;

        // Async reset mid-operation
        wvalid_a = 1'b1; wdata_a = float_t'(32'h7FC00000);
        tick();
        wdata_a = float_t'(32'h3F800000);
        tick();
        wvalid_a = 1'b0;
        check_vec("pre_rst_count", 32'(count_a), 32'd2);
        check_vec("pre_rst_nan", 32'(nan_a), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        check_vec("arst_count", 32'(count_a), 32'd0);
        check_vec("arst_rvalid", 32'(rvalid_a), 32'd0);
        check_vec("arst_wready", 32'(wready_a), 32'd1);
        check_vec("arst_nan", 32'(nan_a), 32'd0);
        #1 rst_a = 1'b0;
        wvalid_a = 1'b1; wdata_a = float_t'(32'h40A00000);
        tick();
        wvalid_a = 1'b0;
        check_vec("post_rst_data", rdata_a, 32'h40A00000);
        check_vec("post_rst_count", 32'(count_a), 32'd1);
        rready_a = 1'b1;
        tick();
        rready_a = 1'b0;
        check_vec("post_rst_empty", 32'(rvalid_a), 32'd0);

        // Streaming across pointer wrap on DEPTH=3
        wvalid_b = 1'b1; wdata_b = float_t'(32'd100);
        tick();
        check_vec("stream_prime", 32'(count_b), 32'd1);
        rready_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wdata_b = float_t'(32'(i));
            check_vec("stream_data", rdata_b, (i == 1) ? 32'd100 : 32'(i - 1));
            tick();
            check_vec("stream_count", 32'(count_b), 32'd1);
        end
        wvalid_b = 1'b0;
        check_vec("stream_last", rdata_b, 32'd10);
        tick();
        rready_b = 1'b0;
        check_vec("stream_empty", 32'(count_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
